iir_sched_ctrl: RTL and testbench



---
 rtl/iir_sched_ctrl.sv | 156 +++++++++++++++
 tb/tb_iir_sched_ctrl.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/iir_sched_ctrl.sv
// Sequencing/configuration front end for iir_filter: paces FIFO'd samples into the filter and
// holds a shadow/active coefficient bank whose swap waits until the filter has drained.
module iir_sched_ctrl #(
  parameter int NB         = 12,
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_OUT    = 7,
  parameter int GAP        = 0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           s_valid,
  input  logic [NB-1:0]                  s_data,
  output logic                           s_ready,
  input  logic                           cfg_we,
  input  logic [2:0]                     cfg_addr,
  input  logic [NB-1:0]                  cfg_wdata,
  input  logic                           cfg_commit,
  output logic                           cfg_busy,
  output logic                           f_vIn,
  output logic [NB-1:0]                  f_dIn,
  output logic [3*NB-1:0]                f_b,
  output logic [2*NB-1:0]                f_a,
  input  logic                           f_vOut,
  output logic [$clog2(MAX_OUT+1)-1:0]   pend_cnt,
  output logic [1:0]                     err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = $clog2(MAX_OUT + 1);
  localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam logic [AW:0]   DEPTH_C = (AW + 1)'(FIFO_DEPTH);
  localparam logic [AW:0]   PTR_ONE = (AW + 1)'(1);
  localparam logic [PW-1:0] MAX_C   = PW'(MAX_OUT);
  localparam logic [PW-1:0] PEND_ONE = PW'(1);
  localparam logic [GW-1:0] GAP_C   = GW'(GAP);
  localparam logic [GW-1:0] GAP_ONE = GW'(1);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_SWAP  = 2'd2
  } state_t;

  state_t          state_r, state_nxt_s;
  logic [NB-1:0]   fifo_mem_r [FIFO_DEPTH];
  logic [AW:0]     wr_ptr_r, rd_ptr_r;
  logic [GW-1:0]   gap_r;
  logic [PW-1:0]   pend_r, pend_nxt_s;
  logic [NB-1:0]   shadow_r [5];
  logic [3*NB-1:0] act_b_r;
  logic [2*NB-1:0] act_a_r;
  logic            vin_r;
  logic [NB-1:0]   din_r;
  logic [1:0]      err_r;
  logic            full_s, empty_s, push_s, issue_s;

  assign full_s  = (wr_ptr_r - rd_ptr_r) == DEPTH_C;
  assign empty_s = (wr_ptr_r == rd_ptr_r);
  assign push_s  = s_valid && !full_s;
  assign issue_s = (state_r == ST_RUN) && !empty_s && (gap_r == {GW{1'b0}}) && (pend_r < MAX_C);

  // Commit sequencing: drain in-flight samples, then one swap cycle
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_RUN: begin
        if (cfg_commit) state_nxt_s = ST_DRAIN;
        else            state_nxt_s = ST_RUN;
      end
      ST_DRAIN: begin
        if ((pend_r == {PW{1'b0}}) && !f_vOut) state_nxt_s = ST_SWAP;
        else                                   state_nxt_s = ST_DRAIN;
      end
      ST_SWAP: state_nxt_s = ST_RUN;
      default: state_nxt_s = ST_RUN;
    endcase
  end

  // In-flight count; a return with nothing outstanding is flagged elsewhere, not counted
  always_comb begin
    pend_nxt_s = pend_r;
    case ({issue_s, f_vOut})
      2'b10: pend_nxt_s = pend_r + PEND_ONE;
      2'b01: begin
        if (pend_r != {PW{1'b0}}) pend_nxt_s = pend_r - PEND_ONE;
        else                      pend_nxt_s = pend_r;
      end
      default: pend_nxt_s = pend_r;
    endcase
  end

  // FIFO, issue pacing and filter-side sample outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_RUN;
      wr_ptr_r <= {(AW + 1){1'b0}};
      rd_ptr_r <= {(AW + 1){1'b0}};
      gap_r    <= {GW{1'b0}};
      pend_r   <= {PW{1'b0}};
      vin_r    <= 1'b0;
      din_r    <= {NB{1'b0}};
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem_r[i] <= {NB{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      pend_r  <= pend_nxt_s;
      vin_r   <= issue_s;
      if (issue_s) begin
        gap_r    <= GAP_C;
        din_r    <= fifo_mem_r[rd_ptr_r[AW-1:0]];
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end else if (gap_r != {GW{1'b0}}) begin
        gap_r <= gap_r - GAP_ONE;
      end
      if (push_s) begin
        fifo_mem_r[wr_ptr_r[AW-1:0]] <= s_data;
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
    end
  end

  // Coefficient banks and sticky error flags; the swap copies the pre-edge shadow contents
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_b_r <= {(3 * NB){1'b0}};
      act_a_r <= {(2 * NB){1'b0}};
      err_r   <= 2'b00;
      for (int i = 0; i < 5; i++) shadow_r[i] <= {NB{1'b0}};
    end else begin
      if (cfg_we) begin
        case (cfg_addr)
          3'd0:    shadow_r[0] <= cfg_wdata;
          3'd1:    shadow_r[1] <= cfg_wdata;
          3'd2:    shadow_r[2] <= cfg_wdata;
          3'd3:    shadow_r[3] <= cfg_wdata;
          3'd4:    shadow_r[4] <= cfg_wdata;
          default: err_r[0]    <= 1'b1;
        endcase
      end
      if (f_vOut && (pend_r == {PW{1'b0}})) err_r[1] <= 1'b1;
      if (state_r == ST_SWAP) begin
        act_b_r <= {shadow_r[2], shadow_r[1], shadow_r[0]};
        act_a_r <= {shadow_r[4], shadow_r[3]};
      end
    end
  end

  assign s_ready  = !full_s;
  assign cfg_busy = (state_r != ST_RUN);
  assign f_vIn    = vin_r;
  assign f_dIn    = din_r;
  assign f_b      = act_b_r;
  assign f_a      = act_a_r;
  assign pend_cnt = pend_r;
  assign err      = err_r;

endmodule

// File: tb/tb_iir_sched_ctrl.sv
// Scoreboard bench for iir_sched_ctrl: a cycle-level reference model of the scheduling rules
// predicts every output; stimulus is a few directed scenarios followed by a random soak.
module tb_iir_sched_ctrl;
  localparam int NB = 12, DEPTH = 4, MAXO = 7, GAP = 2;
  localparam int PW = $clog2(MAXO + 1);

  logic clk, rst_n, s_valid, s_ready, cfg_we, cfg_commit, cfg_busy, f_vIn, f_vOut;
  logic [NB-1:0] s_data, cfg_wdata, f_dIn;
  logic [2:0] cfg_addr;
  logic [3*NB-1:0] f_b;
  logic [2*NB-1:0] f_a;
  logic [PW-1:0] pend_cnt;
  logic [1:0] err;

  iir_sched_ctrl #(.NB(NB), .FIFO_DEPTH(DEPTH), .MAX_OUT(MAXO), .GAP(GAP)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_commit(cfg_commit),
    .cfg_busy(cfg_busy), .f_vIn(f_vIn), .f_dIn(f_dIn), .f_b(f_b), .f_a(f_a),
    .f_vOut(f_vOut), .pend_cnt(pend_cnt), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  int n_iss = 0, n_ret = 0;

  // inputs as the DUT saw them at the last rising edge
  logic sv_q = 1'b0, we_q = 1'b0, cm_q = 1'b0, vo_q = 1'b0;
  logic [NB-1:0] sd_q = '0, wd_q = '0;
  logic [2:0] ad_q = '0;
  always @(posedge clk) begin
    sv_q <= s_valid; sd_q <= s_data; we_q <= cfg_we; ad_q <= cfg_addr;
    wd_q <= cfg_wdata; cm_q <= cfg_commit; vo_q <= f_vOut;
  end

  // reference model: phase 0 = accepting/issuing, 1 = draining, 2 = swapping
  logic [NB-1:0] exp_q[$];
  logic [NB-1:0] m_sh[5];
  logic [NB-1:0] m_act[5];
  int m_pend = 0, m_phase = 0, m_cyc = 0, m_last = -100;
  logic [1:0] m_err = 2'b00;
  int occ_pre, pend_pre;
  bit elig;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, m_cyc);
    end
  endtask

  task automatic m_reset();
    exp_q.delete();
    for (int i = 0; i < 5; i++) begin m_sh[i] = '0; m_act[i] = '0; end
    m_pend = 0; m_phase = 0; m_last = m_cyc - 100; m_err = 2'b00; n_iss = 0;
  endtask

  initial m_reset();

  always @(negedge clk) begin
    if (!rst_n) begin
      m_reset();
      chk("rst_f_vIn", f_vIn, 0);
      chk("rst_f_dIn", f_dIn, 0);
      chk("rst_f_b", f_b, 0);
      chk("rst_f_a", f_a, 0);
      chk("rst_pend", pend_cnt, 0);
      chk("rst_err", err, 0);
      chk("rst_busy", cfg_busy, 0);
      chk("rst_s_ready", s_ready, 1);
    end else begin
      m_cyc++;
      occ_pre  = exp_q.size();
      pend_pre = m_pend;
      elig = (m_phase == 0) && (occ_pre > 0) && (m_cyc - m_last >= GAP + 1) && (pend_pre < MAXO);
      chk("f_vIn", f_vIn, elig);
      if (elig) begin
        chk("f_dIn", f_dIn, exp_q.pop_front());
        m_last = m_cyc;
        n_iss++;
      end
      if (vo_q && pend_pre == 0) m_err[1] = 1'b1;
      if (elig && !vo_q) m_pend = pend_pre + 1;
      else if (!elig && vo_q && pend_pre > 0) m_pend = pend_pre - 1;
      case (m_phase)
        0: if (cm_q) m_phase = 1;
        1: if (pend_pre == 0 && !vo_q) m_phase = 2;
        default: begin
          for (int i = 0; i < 5; i++) m_act[i] = m_sh[i];
          m_phase = 0;
        end
      endcase
      if (we_q) begin
        if (ad_q <= 3'd4) m_sh[ad_q] = wd_q;
        else m_err[0] = 1'b1;
      end
      if (sv_q && occ_pre < DEPTH) exp_q.push_back(sd_q);
      chk("pend_cnt", pend_cnt, m_pend);
      chk("f_b", f_b, {m_act[2], m_act[1], m_act[0]});
      chk("f_a", f_a, {m_act[4], m_act[3]});
      chk("cfg_busy", cfg_busy, m_phase != 0);
      chk("err", err, m_err);
      chk("s_ready", s_ready, exp_q.size() < DEPTH);
    end
  end

  function automatic bit can_ret();
    return (n_iss - n_ret) > 0;
  endfunction

  task automatic cyc(input bit v, input logic [NB-1:0] d, input bit we, input logic [2:0] a,
                     input logic [NB-1:0] wd, input bit cm, input bit vo);
    s_valid = v; s_data = d; cfg_we = we; cfg_addr = a; cfg_wdata = wd;
    cfg_commit = cm; f_vOut = vo;
    if (vo) n_ret++;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n, input bit ret);
    for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b0, 3'd0, '0, 1'b0, ret && can_ret());
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0; s_valid = 1'b0; s_data = '0; cfg_we = 1'b0; cfg_addr = 3'd0;
    cfg_wdata = '0; cfg_commit = 1'b0; f_vOut = 1'b0; n_ret = 0;
    repeat (n) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    do_reset(3);
    // single sample round trip
    cyc(1'b1, 12'h123, 1'b0, 3'd0, '0, 1'b0, 1'b0);
    idle(3, 1'b0);
    idle(4, 1'b1);
    // backpressure: no returns until the in-flight limit and FIFO are both full
    for (int i = 0; i < 30; i++) cyc(1'b1, NB'($urandom), 1'b0, 3'd0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) cyc(1'b1, NB'($urandom), 1'b0, 3'd0, '0, 1'b0, (i % 2 == 0) && can_ret());
    idle(50, 1'b1);
    // clean commit
    cyc(1'b0, '0, 1'b1, 3'd0, 12'h400, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b1, 3'd3, 12'hE00, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b0, 3'd0, '0, 1'b1, 1'b0);
    idle(5, 1'b0);
    // draining commit with a second, ignored commit and continued pushes
    for (int i = 0; i < 3; i++) cyc(1'b1, NB'($urandom), 1'b0, 3'd0, '0, 1'b0, 1'b0);
    idle(8, 1'b0);
    cyc(1'b0, '0, 1'b1, 3'd1, 12'h5A5, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b1, 3'd4, 12'h0F1, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) cyc(1'b1, NB'($urandom), 1'b0, 3'd0, '0, i == 2, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, '0, 1'b0, 3'd0, '0, 1'b0, can_ret());
      idle(2, 1'b0);
    end
    idle(30, 1'b1);
    // random soak
    for (int i = 0; i < 3000; i++)
      cyc(1'($urandom), NB'($urandom), ($urandom % 8) == 0, 3'($urandom_range(0, 7)),
          NB'($urandom), ($urandom % 40) == 0, (($urandom % 3) == 0) && can_ret());
    idle(60, 1'b1);
    // error flags
    do_reset(2);
    cyc(1'b0, '0, 1'b1, 3'd6, 12'hABC, 1'b0, 1'b0);
    idle(2, 1'b0);
    cyc(1'b0, '0, 1'b0, 3'd0, '0, 1'b0, 1'b1);
    idle(2, 1'b0);
    // reset while draining
    cyc(1'b0, '0, 1'b1, 3'd2, 12'h777, 1'b0, 1'b0);
    cyc(1'b1, 12'h011, 1'b0, 3'd0, '0, 1'b0, 1'b0);
    cyc(1'b1, 12'h022, 1'b0, 3'd0, '0, 1'b0, 1'b0);
    idle(5, 1'b0);
    cyc(1'b1, 12'h033, 1'b0, 3'd0, '0, 1'b1, 1'b0);
    idle(2, 1'b0);
    do_reset(2);
    idle(4, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
